timing_ctrl_6502: RTL and testbench

//  Cycle sequencer for the 6502 core. Owns the one-hot T-state register and the SD1/SD2 RMW flag.

---
 rtl/timing_ctrl_6502.sv | 161 ++++++++++++++++
 tb/tb_timing_ctrl_6502.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_ctrl_6502.sv
// Cycle sequencer for the 6502 core: one-hot T-state, SD1/SD2 flag,
// pin synchronisers and RESET/NMI/IRQ request latches.
module timing_ctrl_6502 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       READY,
  input  logic       RnW,
  input  logic       NEXT_T,
  input  logic       CLEAR_T,
  input  logic       BRK,
  input  logic       I_flag,
  input  logic       nRES,
  input  logic       nNMI,
  input  logic       nIRQ,
  output logic [5:0] T_state,
  output logic       SD2,
  output logic       RESET_req,
  output logic       NMI_req,
  output logic       IRQ_req,
  output logic       SYNC,
  output logic       IR_load,
  output logic       IR_force_brk
);

  localparam int unsigned TW = 6;
  localparam int unsigned SW = SYNC_STAGES;

  localparam logic [TW-1:0] T_ZERO = 6'b000000;
  localparam logic [TW-1:0] T0     = 6'b000001;
  localparam logic [TW-1:0] T1     = 6'b000010;
  localparam logic [TW-1:0] T2     = 6'b000100;
  localparam logic [TW-1:0] T3     = 6'b001000;
  localparam logic [TW-1:0] T4     = 6'b010000;
  localparam logic [TW-1:0] T5     = 6'b100000;

  logic [TW-1:0] t_state_q, t_state_d;
  logic          sd2_q, sd2_d;
  logic          reset_req_q, reset_req_d;
  logic          nmi_req_q, nmi_req_d;
  logic          irq_req_q, irq_req_d;
  logic          nmi_prev_q, nmi_prev_d;
  logic [SW-1:0] nres_sync_q, nres_sync_d;
  logic [SW-1:0] nnmi_sync_q, nnmi_sync_d;
  logic [SW-1:0] nirq_sync_q, nirq_sync_d;

  logic stall;
  logic svc;
  logic t_legal;
  logic nres_s;
  logic nnmi_s;
  logic nirq_s;
  logic nmi_fall;

  // State register; reset lands in T1 with the reset request pending.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      t_state_q   <= T1;
      sd2_q       <= 1'b0;
      reset_req_q <= 1'b0;
      nmi_req_q   <= 1'b1;
      irq_req_q   <= 1'b1;
      nmi_prev_q  <= 1'b1;
      nres_sync_q <= '1;
      nnmi_sync_q <= '1;
      nirq_sync_q <= '1;
    end else begin
      t_state_q   <= t_state_d;
      sd2_q       <= sd2_d;
      reset_req_q <= reset_req_d;
      nmi_req_q   <= nmi_req_d;
      irq_req_q   <= irq_req_d;
      nmi_prev_q  <= nmi_prev_d;
      nres_sync_q <= nres_sync_d;
      nnmi_sync_q <= nnmi_sync_d;
      nirq_sync_q <= nirq_sync_d;
    end
  end

  // Next-state: T sequencing, synchroniser shift and request latches.
  always_comb begin
    stall    = ~READY & RnW;
    svc      = BRK & t_state_q[5] & ~stall;
    t_legal  = ((t_state_q & (t_state_q - 6'd1)) == T_ZERO);
    nres_s   = nres_sync_q[SW-1];
    nnmi_s   = nnmi_sync_q[SW-1];
    nirq_s   = nirq_sync_q[SW-1];
    nmi_fall = nmi_prev_q & ~nnmi_s;

    t_state_d   = t_state_q;
    sd2_d       = sd2_q;
    reset_req_d = reset_req_q;
    nmi_req_d   = nmi_req_q;
    irq_req_d   = nirq_s | I_flag;
    nmi_prev_d  = nnmi_s;

    // Stage 0 takes the pin, the last stage feeds the request logic.
    nres_sync_d = SW'({nres_sync_q, nRES});
    nnmi_sync_d = SW'({nnmi_sync_q, nNMI});
    nirq_sync_d = SW'({nirq_sync_q, nIRQ});

    if (!stall) begin
      sd2_d = 1'b0;
      if (!t_legal) begin
        t_state_d = T1;
      end else if (CLEAR_T) begin
        t_state_d = T_ZERO;
      end else if (NEXT_T) begin
        t_state_d = T0;
      end else begin
        case (t_state_q)
          T0:      t_state_d = T1;
          T1:      t_state_d = T2;
          T2:      t_state_d = T3;
          T3:      t_state_d = T4;
          T4:      t_state_d = T5;
          T5:      t_state_d = T_ZERO;
          default: begin
            // All-zero state lasts at most two cycles.
            if (sd2_q) begin
              t_state_d = T0;
            end else begin
              t_state_d = T_ZERO;
              sd2_d     = 1'b1;
            end
          end
        endcase
      end
    end

    // Service clears the highest pending request; new events override.
    if (svc) begin
      if (!reset_req_q) begin
        reset_req_d = 1'b1;
      end else if (!nmi_req_q) begin
        nmi_req_d = 1'b1;
      end
    end
    if (!nres_s) begin
      reset_req_d = 1'b0;
    end
    if (nmi_fall) begin
      nmi_req_d = 1'b0;
    end
  end

  // Decoder-facing outputs.
  always_comb begin
    SYNC         = t_state_q[1];
    IR_load      = t_state_q[1] & ~stall;
    IR_force_brk = t_state_q[1] & ~(reset_req_q & nmi_req_q & irq_req_q);
  end

  assign T_state   = t_state_q;
  assign SD2       = sd2_q;
  assign RESET_req = reset_req_q;
  assign NMI_req   = nmi_req_q;
  assign IRQ_req   = irq_req_q;

endmodule

// File: tb/tb_timing_ctrl_6502.sv
// Bench for timing_ctrl_6502: cycle-level behavioural model plus
// directed scenarios with literal expectations.
module tb_timing_ctrl_6502;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       nRESET, READY, RnW, NEXT_T, CLEAR_T, BRK, I_flag, nRES, nNMI, nIRQ;
  logic [5:0] T_state;
  logic       SD2, RESET_req, NMI_req, IRQ_req, SYNC, IR_load, IR_force_brk;

  always #5 clk = ~clk;

  timing_ctrl_6502 #(.SYNC_STAGES(S)) dut (
    .clk(clk), .nRESET(nRESET), .READY(READY), .RnW(RnW), .NEXT_T(NEXT_T),
    .CLEAR_T(CLEAR_T), .BRK(BRK), .I_flag(I_flag), .nRES(nRES), .nNMI(nNMI),
    .nIRQ(nIRQ), .T_state(T_state), .SD2(SD2), .RESET_req(RESET_req),
    .NMI_req(NMI_req), .IRQ_req(IRQ_req), .SYNC(SYNC), .IR_load(IR_load),
    .IR_force_brk(IR_force_brk)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: T number 0..5, 6 = all-zero state; pins recorded per edge.
  int         e = 0;
  int         rst_e = 0;
  bit         mvalid = 0;
  int         tn = 1;
  bit         m_sd2, m_rreq, m_nreq, m_ireq;
  logic [2:0] pins [0:4095];

  // Value seen at the synchroniser output after edge k ({irq,nmi,res}).
  function automatic logic [2:0] synced3(input int k);
    if (k - rst_e < int'(S)) return 3'b111;
    return pins[k - int'(S) + 1];
  endfunction

  function automatic logic [5:0] exp_t(input int n);
    if (n == 6) return 6'b0;
    return 6'(1 << n);
  endfunction

  always @(posedge clk) begin
    logic [2:0] s1, s2;
    bit st, sv, ordq, onrq;
    e++;
    pins[e] = {nIRQ, nNMI, nRES};
    if (!nRESET) begin
      rst_e  = e;
      tn     = 1;
      m_sd2  = 0;
      m_rreq = 0;
      m_nreq = 1;
      m_ireq = 1;
      mvalid = 1;
    end else begin
      s1   = synced3(e - 1);
      s2   = synced3(e - 2);
      st   = !READY && RnW;
      sv   = BRK && tn == 5 && !st;
      ordq = m_rreq;
      onrq = m_nreq;
      m_ireq = s1[2] | I_flag;
      if (!s1[0]) m_rreq = 0;
      else if (sv && !ordq) m_rreq = 1;
      if (s2[1] && !s1[1]) m_nreq = 0;
      else if (sv && ordq && !onrq) m_nreq = 1;
      if (!st) begin
        if (CLEAR_T) begin tn = 6; m_sd2 = 0; end
        else if (NEXT_T) begin tn = 0; m_sd2 = 0; end
        else if (tn == 6) begin
          if (m_sd2) begin tn = 0; m_sd2 = 0; end
          else m_sd2 = 1;
        end else begin
          tn = tn + 1;
          m_sd2 = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_T_state", 32'(T_state), 32'(exp_t(tn)));
      chk("m_SD2", 32'(SD2), 32'(m_sd2));
      chk("m_RESET_req", 32'(RESET_req), 32'(m_rreq));
      chk("m_NMI_req", 32'(NMI_req), 32'(m_nreq));
      chk("m_IRQ_req", 32'(IRQ_req), 32'(m_ireq));
      chk("m_SYNC", 32'(SYNC), 32'(tn == 1));
      chk("m_IR_load", 32'(IR_load), 32'(tn == 1 && !(!READY && RnW)));
      chk("m_IR_force_brk", 32'(IR_force_brk), 32'(tn == 1 && !(m_rreq && m_nreq && m_ireq)));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic goto_t0();
    NEXT_T = 1'b1;
    tick();
    NEXT_T = 1'b0;
  endtask

  logic [5:0] seq_t   [8] = '{6'b000100, 6'b001000, 6'b010000, 6'b100000,
                              6'b000000, 6'b000000, 6'b000001, 6'b000010};
  logic       seq_sd2 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       seq_rr  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    nRESET = 0; READY = 1; RnW = 1; NEXT_T = 0; CLEAR_T = 0; BRK = 1;
    I_flag = 1; nRES = 1; nNMI = 1; nIRQ = 1;
    tick(); tick();
    chk("rst_T_state", 32'(T_state), 32'h02);
    chk("rst_SD2", 32'(SD2), 32'h0);
    chk("rst_RESET_req", 32'(RESET_req), 32'h0);
    chk("rst_NMI_req", 32'(NMI_req), 32'h1);
    chk("rst_IRQ_req", 32'(IRQ_req), 32'h1);
    chk("rst_IR_force_brk", 32'(IR_force_brk), 32'h1);

    // Reset vector sequence
    nRESET = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rseq_T_state", 32'(T_state), 32'(seq_t[i]));
      chk("rseq_SD2", 32'(SD2), 32'(seq_sd2[i]));
      chk("rseq_RESET_req", 32'(RESET_req), 32'(seq_rr[i]));
    end
    chk("rseq_IR_force_brk", 32'(IR_force_brk), 32'h0);
    BRK = 0;

    // CLEAR_T beats NEXT_T; SD2 exits to T0 without NEXT_T
    tick();
    chk("clr_T2", 32'(T_state), 32'h04);
    CLEAR_T = 1; NEXT_T = 1;
    tick();
    chk("clr_sd1_T", 32'(T_state), 32'h00);
    chk("clr_sd1_SD2", 32'(SD2), 32'h0);
    CLEAR_T = 0; NEXT_T = 0;
    tick();
    chk("clr_sd2_T", 32'(T_state), 32'h00);
    chk("clr_sd2_SD2", 32'(SD2), 32'h1);
    tick();
    chk("clr_exit_T0", 32'(T_state), 32'h01);
    tick();

    // Read stall at T1, write cycle does not stall
    READY = 0; RnW = 1;
    #1 chk("stall_IR_load", 32'(IR_load), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_T_hold", 32'(T_state), 32'h02);
      chk("stall_IR_load_hold", 32'(IR_load), 32'h0);
    end
    RnW = 0;
    #1 chk("wr_IR_load", 32'(IR_load), 32'h1);
    tick();
    chk("wr_advance", 32'(T_state), 32'h04);
    READY = 1; RnW = 1;

    // Reset mid-instruction, then service via BRK
    tick();
    nRESET = 0;
    tick();
    chk("mid_rst_T", 32'(T_state), 32'h02);
    chk("mid_rst_RESET_req", 32'(RESET_req), 32'h0);
    nRESET = 1; BRK = 1;
    repeat (5) tick();
    chk("mid_rst_clear", 32'(RESET_req), 32'h1);
    goto_t0(); tick();
    BRK = 0;

    // NMI edge: one request, cleared once by the BRK sequence
    nNMI = 0;
    tick(); chk("nmi_e1", 32'(NMI_req), 32'h1);
    tick(); chk("nmi_e2", 32'(NMI_req), 32'h1);
    tick(); chk("nmi_e3", 32'(NMI_req), 32'h0);
    BRK = 1;
    tick(); chk("nmi_T5_pending", 32'(NMI_req), 32'h0);
    tick(); chk("nmi_cleared", 32'(NMI_req), 32'h1);
    repeat (12) tick();
    chk("nmi_no_second", 32'(NMI_req), 32'h1);
    nNMI = 1; BRK = 0;
    repeat (3) tick();

    // IRQ level with mask
    nIRQ = 0; I_flag = 1;
    repeat (3) tick();
    chk("irq_masked", 32'(IRQ_req), 32'h1);
    I_flag = 0;
    tick();
    chk("irq_unmasked", 32'(IRQ_req), 32'h0);
    goto_t0(); tick();
    chk("irq_force_brk", 32'(IR_force_brk), 32'h1);
    I_flag = 1; nIRQ = 1;
    repeat (3) tick();
    chk("irq_released", 32'(IRQ_req), 32'h1);

    // New NMI edge on the same edge as the NMI service clear
    goto_t0(); tick();
    nNMI = 0; tick();
    nNMI = 1; tick();
    nNMI = 0; tick();
    chk("nmi2_pending", 32'(NMI_req), 32'h0);
    BRK = 1;
    tick();
    chk("nmi2_T5", 32'(T_state), 32'h20);
    tick();
    chk("nmi_set_wins", 32'(NMI_req), 32'h0);
    repeat (8) tick();
    chk("nmi2_cleared", 32'(NMI_req), 32'h1);
    nNMI = 1; BRK = 0;

    // External reset pin: latency and hold past service
    nRES = 0;
    tick(); chk("nres_e1", 32'(RESET_req), 32'h1);
    tick(); chk("nres_e2", 32'(RESET_req), 32'h1);
    tick(); chk("nres_e3", 32'(RESET_req), 32'h0);
    BRK = 1;
    goto_t0();
    repeat (6) tick();
    chk("nres_hold", 32'(RESET_req), 32'h0);
    nRES = 1;
    repeat (3) tick();
    goto_t0();
    repeat (6) tick();
    chk("nres_cleared", 32'(RESET_req), 32'h1);
    BRK = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
